// File: rtl/interval_timer_ctrl_if.sv
// Control/status bundle for interval_timer_ctrl: software strobes and mode inputs in,
// counter value and status flags out.
interface interval_timer_ctrl_if #(
    parameter int unsigned N = 8
);
    logic         start;
    logic         stop;
    logic         pause;
    logic         periodic;
    logic         dir_up;
    logic [N-1:0] period;
    logic [N-1:0] cnt;
    logic         busy;
    logic         paused;
    logic         done;
    logic         expire;
    logic         err;

    modport master (
        output start, stop, pause, periodic, dir_up, period,
        input  cnt, busy, paused, done, expire, err
    );

    modport slave (
        input  start, stop, pause, periodic, dir_up, period,
        output cnt, busy, paused, done, expire, err
    );
endinterface

// File: rtl/interval_timer_ctrl.sv
// Programmable interval timer: N-bit up/down counter sequenced through
// IDLE/RUN/HOLD/DONE, with one-shot or periodic expiry pulses.
module interval_timer_ctrl #(
    parameter int unsigned N = 8
) (
    input logic                  clk,
    input logic                  reset,
    interval_timer_ctrl_if.slave tmr_io
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StHold = 2'b10,
        StDone = 2'b11
    } state_e;

    state_e       state_q, state_d;
    logic [N-1:0] cnt_q, cnt_d;
    logic [N-1:0] period_q, period_d;
    logic         periodic_q, periodic_d;
    logic         dir_up_q, dir_up_d;
    logic         expire_q, expire_d;
    logic         err_q, err_d;

    logic [N-1:0] term_val;
    logic [N-1:0] start_val;
    logic         at_term;
    logic         start_ok;
    logic         start_bad;

    assign term_val  = dir_up_q ? period_q : '0;
    assign start_val = dir_up_q ? '0 : period_q;
    assign at_term   = (cnt_q == term_val);
    assign start_ok  = tmr_io.start && (tmr_io.period != '0);
    assign start_bad = tmr_io.start && (tmr_io.period == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            period_q   <= '0;
            periodic_q <= 1'b0;
            dir_up_q   <= 1'b0;
            expire_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            periodic_q <= periodic_d;
            dir_up_q   <= dir_up_d;
            expire_q   <= expire_d;
            err_q      <= err_d;
        end
    end

    // Next state: stop beats start beats pause beats terminal detection.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (tmr_io.stop) begin
                    state_d = StIdle;
                end else if (start_ok) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (tmr_io.stop) begin
                    state_d = StIdle;
                end else if (tmr_io.pause) begin
                    state_d = StHold;
                end else if (at_term && !periodic_q) begin
                    state_d = StDone;
                end
            end
            StHold: begin
                if (tmr_io.stop) begin
                    state_d = StIdle;
                end else if (!tmr_io.pause) begin
                    state_d = StRun;
                end
            end
        endcase
    end

    // Datapath next state; start in RUN/HOLD has no effect.
    always_comb begin
        cnt_d      = cnt_q;
        period_d   = period_q;
        periodic_d = periodic_q;
        dir_up_d   = dir_up_q;
        expire_d   = 1'b0;
        err_d      = 1'b0;
        if (tmr_io.stop) begin
            cnt_d = '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start_ok) begin
                        period_d   = tmr_io.period;
                        periodic_d = tmr_io.periodic;
                        dir_up_d   = tmr_io.dir_up;
                        cnt_d      = tmr_io.dir_up ? '0 : tmr_io.period;
                    end else if (start_bad) begin
                        err_d = 1'b1;
                    end
                end
                StRun: begin
                    if (!tmr_io.pause) begin
                        if (at_term) begin
                            expire_d = 1'b1;
                            if (periodic_q) begin
                                cnt_d = start_val;
                            end
                        end else if (dir_up_q) begin
                            cnt_d = cnt_q + 1'b1;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end
                StHold: begin
                    cnt_d = cnt_q;
                end
            endcase
        end
    end

    always_comb begin
        tmr_io.cnt    = cnt_q;
        tmr_io.busy   = (state_q == StRun) || (state_q == StHold);
        tmr_io.paused = (state_q == StHold);
        tmr_io.done   = (state_q == StDone);
        tmr_io.expire = expire_q;
        tmr_io.err    = err_q;
    end

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Self-checking bench for interval_timer_ctrl: directed vector table, corner-case
// sequences and randomized stimulus against an elapsed-ticks reference model.
module tb_interval_timer_ctrl;

    localparam int unsigned N = 8;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    interval_timer_ctrl_if #(.N(N)) tif ();

    interval_timer_ctrl #(.N(N)) dut (
        .clk    (clk),
        .reset  (reset_n),
        .tmr_io (tif)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: progress tracked as elapsed ticks since (re)load.
    bit m_run, m_hold, m_fin;
    int m_ticks, m_per;
    bit m_periodic, m_up;
    bit m_expire, m_err;

    typedef struct {
        logic       rst;
        logic       st;
        logic       sp;
        logic       pa;
        logic       pe;
        logic       du;
        logic [7:0] pd;
        int         e_cnt;
        logic       e_busy;
        logic       e_paused;
        logic       e_done;
        logic       e_expire;
        logic       e_err;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    function automatic int model_cnt();
        if (m_run || m_hold || m_fin) return m_up ? m_ticks : (m_per - m_ticks);
        return 0;
    endfunction

    task automatic model_step();
        m_expire = 1'b0;
        m_err    = 1'b0;
        if (!reset_n) begin
            m_run = 0; m_hold = 0; m_fin = 0; m_ticks = 0;
            m_per = 0; m_periodic = 0; m_up = 0;
        end else if (tif.stop) begin
            m_run = 0; m_hold = 0; m_fin = 0; m_ticks = 0;
        end else if (!m_run && !m_hold && tif.start) begin
            if (tif.period != 0) begin
                m_per = int'(tif.period); m_periodic = tif.periodic; m_up = tif.dir_up;
                m_run = 1; m_fin = 0; m_ticks = 0;
            end else begin
                m_err = 1'b1;
            end
        end else if (m_run) begin
            if (tif.pause) begin
                m_run = 0; m_hold = 1;
            end else if (m_ticks == m_per) begin
                m_expire = 1'b1;
                if (m_periodic) m_ticks = 0;
                else begin m_run = 0; m_fin = 1; end
            end else begin
                m_ticks++;
            end
        end else if (m_hold && !tif.pause) begin
            m_hold = 0; m_run = 1;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".cnt"},    int'(tif.cnt),    model_cnt());
        check({tag, ".busy"},   int'(tif.busy),   int'(m_run || m_hold));
        check({tag, ".paused"}, int'(tif.paused), int'(m_hold));
        check({tag, ".done"},   int'(tif.done),   int'(m_fin));
        check({tag, ".expire"}, int'(tif.expire), int'(m_expire));
        check({tag, ".err"},    int'(tif.err),    int'(m_err));
    endtask

    task automatic drive(input logic rst, input logic st, input logic sp, input logic pa,
                         input logic pe, input logic du, input logic [7:0] pd);
        reset_n      = rst;
        tif.start    = st;
        tif.stop     = sp;
        tif.pause    = pa;
        tif.periodic = pe;
        tif.dir_up   = du;
        tif.period   = pd;
    endtask

    task automatic tick(input bit cmp, input string tag);
        @(posedge clk);
        model_step();
        #1;
        if (cmp) check_model(tag);
    endtask

    initial begin
        int  n;
        bit  p_pause;

        //            rst st sp pa pe du pd    cnt busy psd done exp err
        vecs[0]  = '{1'b0, 1, 0, 0, 0, 1, 8'd3, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{1'b1, 0, 0, 0, 0, 1, 8'd3, 0, 0, 0, 0, 0, 0};
        vecs[2]  = '{1'b1, 1, 0, 0, 0, 1, 8'd3, 0, 1, 0, 0, 0, 0};
        vecs[3]  = '{1'b1, 0, 0, 0, 0, 1, 8'd3, 1, 1, 0, 0, 0, 0};
        vecs[4]  = '{1'b1, 0, 0, 0, 0, 1, 8'd3, 2, 1, 0, 0, 0, 0};
        vecs[5]  = '{1'b1, 0, 0, 0, 0, 1, 8'd3, 3, 1, 0, 0, 0, 0};
        vecs[6]  = '{1'b1, 0, 0, 0, 0, 1, 8'd3, 3, 0, 0, 1, 1, 0};
        vecs[7]  = '{1'b1, 0, 0, 0, 0, 1, 8'd3, 3, 0, 0, 1, 0, 0};
        vecs[8]  = '{1'b1, 1, 0, 0, 0, 1, 8'd0, 3, 0, 0, 1, 0, 1};
        vecs[9]  = '{1'b1, 0, 1, 0, 0, 1, 8'd0, 0, 0, 0, 0, 0, 0};
        vecs[10] = '{1'b1, 1, 0, 0, 0, 1, 8'd0, 0, 0, 0, 0, 0, 1};
        vecs[11] = '{1'b1, 0, 0, 0, 0, 1, 8'd0, 0, 0, 0, 0, 0, 0};
        vecs[12] = '{1'b1, 1, 0, 0, 1, 0, 8'd2, 2, 1, 0, 0, 0, 0};
        vecs[13] = '{1'b1, 0, 0, 0, 0, 1, 8'd5, 1, 1, 0, 0, 0, 0};
        vecs[14] = '{1'b1, 0, 0, 0, 0, 1, 8'd5, 0, 1, 0, 0, 0, 0};
        vecs[15] = '{1'b1, 0, 0, 0, 0, 1, 8'd5, 2, 1, 0, 0, 1, 0};
        vecs[16] = '{1'b1, 0, 0, 0, 0, 1, 8'd5, 1, 1, 0, 0, 0, 0};
        vecs[17] = '{1'b1, 1, 1, 0, 1, 1, 8'd5, 0, 0, 0, 0, 0, 0};

        drive(1'b0, 0, 0, 0, 0, 0, 8'd0);
        tick(0, "init");

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].st, vecs[i].sp, vecs[i].pa, vecs[i].pe, vecs[i].du,
                  vecs[i].pd);
            tick(0, "vec");
            check($sformatf("vec%0d.cnt", i),    int'(tif.cnt),    vecs[i].e_cnt);
            check($sformatf("vec%0d.busy", i),   int'(tif.busy),   int'(vecs[i].e_busy));
            check($sformatf("vec%0d.paused", i), int'(tif.paused), int'(vecs[i].e_paused));
            check($sformatf("vec%0d.done", i),   int'(tif.done),   int'(vecs[i].e_done));
            check($sformatf("vec%0d.expire", i), int'(tif.expire), int'(vecs[i].e_expire));
            check($sformatf("vec%0d.err", i),    int'(tif.err),    int'(vecs[i].e_err));
        end

        // Pause at cnt=4 for 5 cycles, resume, stop at cnt=7.
        drive(1'b1, 1, 0, 0, 0, 1, 8'd10);
        tick(1, "ps_start");
        drive(1'b1, 0, 0, 0, 0, 1, 8'd10);
        repeat (4) tick(1, "ps_run");
        check("ps_cnt4", int'(tif.cnt), 4);
        drive(1'b1, 0, 0, 1, 0, 1, 8'd10);
        for (int i = 0; i < 5; i++) begin
            tick(1, "ps_hold");
            check("ps_hold_cnt", int'(tif.cnt), 4);
            check("ps_hold_paused", int'(tif.paused), 1);
        end
        drive(1'b1, 0, 0, 0, 0, 1, 8'd10);
        tick(1, "ps_resume");
        check("ps_resume_cnt", int'(tif.cnt), 4);
        tick(1, "ps_run2");
        check("ps_cnt5", int'(tif.cnt), 5);
        repeat (2) tick(1, "ps_run3");
        check("ps_cnt7", int'(tif.cnt), 7);
        drive(1'b1, 0, 1, 0, 0, 1, 8'd10);
        tick(1, "ps_stop");
        check("ps_stop_cnt", int'(tif.cnt), 0);
        check("ps_stop_busy", int'(tif.busy), 0);
        check("ps_stop_expire", int'(tif.expire), 0);

        // Reset asserted mid-run at cnt=6.
        drive(1'b1, 1, 0, 0, 0, 1, 8'd20);
        tick(1, "rs_start");
        drive(1'b1, 0, 0, 0, 0, 1, 8'd20);
        repeat (6) tick(1, "rs_run");
        check("rs_cnt6", int'(tif.cnt), 6);
        drive(1'b0, 0, 0, 0, 0, 1, 8'd20);
        tick(1, "rs_reset");
        check("rs_cnt0", int'(tif.cnt), 0);
        check("rs_busy0", int'(tif.busy), 0);
        drive(1'b1, 0, 0, 0, 0, 1, 8'd20);
        tick(1, "rs_release");

        // Full-range one-shot: expire exactly 256 cycles after start, no wrap.
        drive(1'b1, 1, 0, 0, 0, 1, 8'd255);
        tick(1, "mx_start");
        drive(1'b1, 0, 0, 0, 1, 0, 8'd7);
        n = 0;
        while (!tif.expire && n < 300) begin
            tick(1, "mx_run");
            n++;
        end
        check("mx_latency", n, 256);
        check("mx_cnt", int'(tif.cnt), 255);
        tick(1, "mx_hold");
        check("mx_hold_cnt", int'(tif.cnt), 255);
        check("mx_done", int'(tif.done), 1);

        // Randomized traffic against the model.
        drive(1'b0, 0, 0, 0, 0, 0, 8'd0);
        tick(1, "rnd_reset");
        p_pause = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) p_pause = ~p_pause;
            drive(($urandom_range(0, 149) != 0),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 39) == 0),
                  p_pause,
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 12)));
            tick(1, $sformatf("rnd%0d", c));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
